// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// BPC bits per cycle, with 1-cycle resolution of divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int STEPS = XLEN / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] hi, lo, opnd;

  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  // Operand signedness and magnitudes are decided once, when the op is accepted.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & srca[XLEN-1];
    b_neg    = b_signed & srcb[XLEN-1];
    a_mag    = a_neg ? -srca : srca;
    b_mag    = b_neg ? -srcb : srcb;
    div_zero = funct3[2] && (srcb == '0);
    div_ovf  = funct3[2] && !funct3[0] && (srca == {1'b1, {(XLEN-1){1'b0}}}) && (srcb == '1);
    if (div_zero)
      special_res = funct3[1] ? srca : '1;
    else
      special_res = funct3[1] ? '0 : srca;
  end

  logic [XLEN-1:0] hi_n, lo_n;
  logic [XLEN:0]   sum, sh;

  // One iteration = BPC unrolled steps; {hi,lo} is the product or {remainder,quotient}.
  always_comb begin
    hi_n = hi;
    lo_n = lo;
    sum  = '0;
    sh   = '0;
    for (int i = 0; i < BPC; i++) begin
      if (op[2]) begin
        sh = {hi_n, lo_n[XLEN-1]};
        if (sh >= {1'b0, opnd}) begin
          sh   = sh - {1'b0, opnd};
          lo_n = {lo_n[XLEN-2:0], 1'b1};
        end else begin
          lo_n = {lo_n[XLEN-2:0], 1'b0};
        end
        hi_n = sh[XLEN-1:0];
      end else begin
        sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, opnd} : '0);
        lo_n = {sum[0], lo_n[XLEN-1:1]};
        hi_n = sum[XLEN:1];
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quo  = neg_q ? -lo_n : lo_n;
    rem  = neg_r ? -hi_n : hi_n;
    case (op)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  // Flush wins over both a new start and completion of the running op.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (start) begin
            op    <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            count <= '0;
            hi    <= '0;
            lo    <= funct3[2] ? a_mag : b_mag;
            opnd  <= funct3[2] ? b_mag : a_mag;
            if (div_zero || div_ovf) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= special_res;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            hi    <= hi_n;
            lo    <= lo_n;
            count <= count + 1'b1;
            if (count == CW'(STEPS - 1)) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= final_res;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = (state != RUN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: table of M-extension vectors on XLEN=32 units with BPC=1 and BPC=4,
// scoreboard queues popped on done, plus flush, reset and back-to-back sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start32, start4, flush;
  logic [2:0]  funct3;
  logic [31:0] srca, srcb;
  logic        ready32, busy32, done32, ready4, busy4, done4;
  logic [31:0] result32, result4;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .BPC(1)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .funct3(funct3), .srca(srca), .srcb(srcb),
    .flush(flush), .ready(ready32), .busy(busy32), .done(done32), .result(result32));

  muldiv_unit #(.XLEN(32), .BPC(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .funct3(funct3), .srca(srca), .srcb(srcb),
    .flush(flush), .ready(ready4), .busy(busy4), .done(done4), .result(result4));

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    bit          use4;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] q32[$];
  logic [31:0] q4[$];
  logic [31:0] exp32, exp4;
  int          nCompared = 0;
  int          nMismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit use4);
    vec_t v;
    v.name = name; v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.use4 = use4;
    vecs.push_back(v);
  endtask

  // Scoreboards: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done32) begin
      if (q32.size() == 0) begin
        nCompared++; nMismatched++;
        $display("[TB] FAIL spurious_done32: got done=1, expected no done");
      end else begin
        exp32 = q32.pop_front();
        checkOutput("result32", result32, exp32);
      end
    end
    if (reset_n && done4) begin
      if (q4.size() == 0) begin
        nCompared++; nMismatched++;
        $display("[TB] FAIL spurious_done4: got done=1, expected no done");
      end else begin
        exp4 = q4.pop_front();
        checkOutput("result4", result4, exp4);
      end
    end
    if (reset_n && ((busy32 && done32) || (busy4 && done4))) begin
      nCompared++; nMismatched++;
      $display("[TB] FAIL busy_and_done: got both 1, expected exclusive");
    end
  end

  task automatic waitDone(input string name, input int firstCyc, input int lat, input bit use4);
    int  cyc = firstCyc;
    int  busyCnt = firstCyc - 1;
    bit  seen = 1'b0;
    while (!seen && cyc <= 100) begin
      @(negedge clk);
      if (use4 ? done4 : done32) seen = 1'b1;
      else begin
        if (use4 ? busy4 : busy32) busyCnt++;
        cyc++;
      end
    end
    if (!seen) begin
      nCompared++; nMismatched++;
      $display("[TB] FAIL %s timeout: got no done in 100 cycles, expected done in cycle %0d", name, lat);
      if (use4) q4.delete(); else q32.delete();
    end else begin
      checkOutput({name, " done cycle"}, cyc, lat);
      checkOutput({name, " busy cycles"}, busyCnt, lat - 1);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    if (v.use4) q4.push_back(v.exp); else q32.push_back(v.exp);
    funct3 = v.f3; srca = v.a; srcb = v.b;
    start32 = !v.use4; start4 = v.use4;
    @(posedge clk); #1;
    start32 = 1'b0; start4 = 1'b0;
    waitDone(v.name, 1, v.lat, v.use4);
  endtask

  initial begin
    reset_n = 1'b0; start32 = 1'b0; start4 = 1'b0; flush = 1'b0;
    funct3 = 3'b000; srca = '0; srcb = '0;

    addVec("MUL 7*-3",        3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    addVec("MULH min*min",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    addVec("MULHU max*max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    addVec("MULHSU -1*max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    addVec("MUL lo",          3'b000, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 33, 0);
    addVec("MULH -1*5",       3'b001, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 33, 0);
    addVec("DIV -7/2",        3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33, 0);
    addVec("REM -7/2",        3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33, 0);
    addVec("DIVU 7/2",        3'b101, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 33, 0);
    addVec("REMU 7/2",        3'b111, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 33, 0);
    addVec("DIV 100/-7",      3'b100, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 0);
    addVec("REM 100/-7",      3'b110, 32'h0000_0064, 32'hFFFF_FFF9, 32'h0000_0002, 33, 0);
    addVec("DIVU max/1",      3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33, 0);
    addVec("REMU 2^31/3",     3'b111, 32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 33, 0);
    addVec("DIV min/min",     3'b100, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 33, 0);
    addVec("DIV 5/0",         3'b100, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0);
    addVec("REMU 5/0",        3'b111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1, 0);
    addVec("DIV ovf",         3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    addVec("REM ovf",         3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    addVec("BPC4 MUL 7*-3",   3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 9, 1);
    addVec("BPC4 DIV -7/2",   3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 9, 1);
    addVec("BPC4 MULHU",      3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, 1);
    addVec("BPC4 DIVU 5/0",   3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset result32", result32, 32'h0);
    checkOutput("reset busy32", {31'b0, busy32}, 32'h0);
    checkOutput("reset done32", {31'b0, done32}, 32'h0);
    checkOutput("reset ready32", {31'b0, ready32}, 32'h1);
    checkOutput("reset result4", result4, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Back-to-back: new start during the DONE cycle, plus a start while busy that must be ignored.
    applyStimulus(vecs[8]);
    q32.push_back(32'h0000_000C);
    funct3 = 3'b000; srca = 32'h3; srcb = 32'h4; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    @(negedge clk);
    checkOutput("b2b busy", {31'b0, busy32}, 32'h1);
    checkOutput("b2b done", {31'b0, done32}, 32'h0);
    @(posedge clk); #1;
    funct3 = 3'b101; srca = 32'd100; srcb = 32'h0; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    waitDone("b2b MUL 3*4", 3, 33, 0);

    // Flush at cycle 10 of a DIVU: no done, result keeps 12 from the MUL above.
    @(posedge clk); #1;
    funct3 = 3'b101; srca = 32'hFFFF_FFFF; srcb = 32'h3; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush cycle10 busy", {31'b0, busy32}, 32'h1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush cycle11 busy", {31'b0, busy32}, 32'h0);
    checkOutput("flush cycle11 ready", {31'b0, ready32}, 32'h1);
    checkOutput("flush result held", result32, 32'h0000_000C);
    begin
      int doneCnt = 0;
      repeat (40) begin
        @(negedge clk);
        if (done32) doneCnt++;
      end
      checkOutput("flush no done", doneCnt, 0);
    end

    // Asynchronous reset in cycle 5 of a running MUL.
    @(posedge clk); #1;
    funct3 = 3'b000; srca = 32'h7; srcb = 32'hFFFF_FFFD; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("pre-reset busy", {31'b0, busy32}, 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset busy", {31'b0, busy32}, 32'h0);
    checkOutput("async reset done", {31'b0, done32}, 32'h0);
    checkOutput("async reset result", result32, 32'h0);
    checkOutput("async reset ready", {31'b0, ready32}, 32'h1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);

    checkOutput("scoreboard32 drained", q32.size(), 0);
    checkOutput("scoreboard4 drained", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
